// File: rtl/axi4_tlp_rr_arbiter.sv
// Two-source, packet-granular round-robin arbiter for a 512-bit AXI4-Stream TLP channel.
// The grant is held from a packet's first beat to its TLAST beat, and the output has one register stage.
module axi4_tlp_rr_arbiter #(
  parameter int AXI_TUSER_L = 161,
  parameter int MAX_BEATS   = 256
) (
  input  logic                   ACLK,
  input  logic                   ARESETN,
  input  logic [511:0]           S0_AXIS_TDATA,
  input  logic [15:0]            S0_AXIS_TKEEP,
  input  logic [AXI_TUSER_L-1:0] S0_AXIS_TUSER,
  input  logic                   S0_AXIS_TLAST,
  input  logic                   S0_AXIS_TVALID,
  output logic                   S0_AXIS_TREADY,
  input  logic [511:0]           S1_AXIS_TDATA,
  input  logic [15:0]            S1_AXIS_TKEEP,
  input  logic [AXI_TUSER_L-1:0] S1_AXIS_TUSER,
  input  logic                   S1_AXIS_TLAST,
  input  logic                   S1_AXIS_TVALID,
  output logic                   S1_AXIS_TREADY,
  output logic [511:0]           M_AXIS_TDATA,
  output logic [15:0]            M_AXIS_TKEEP,
  output logic [AXI_TUSER_L-1:0] M_AXIS_TUSER,
  output logic                   M_AXIS_TLAST,
  output logic                   M_AXIS_TVALID,
  input  logic                   M_AXIS_TREADY,
  output logic                   grant_id,
  output logic                   error_pkt_overrun,
  output logic [1:0]             o_dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2
  } state_t;

  localparam int              CW      = $clog2(MAX_BEATS + 1);
  localparam logic [CW-1:0]   MAX_CNT = CW'(MAX_BEATS);

  state_t                 r_state;
  logic                   r_rr_ptr;
  logic                   r_grant_id;
  logic [CW-1:0]          r_beat_cnt;
  logic                   r_overrun;
  logic [511:0]           r_m_tdata;
  logic [15:0]            r_m_tkeep;
  logic [AXI_TUSER_L-1:0] r_m_tuser;
  logic                   r_m_tlast;
  logic                   r_m_tvalid;

  logic w_out_free;
  logic w_acc0;
  logic w_acc1;
  logic w_acc;
  logic w_tlast_in;

  // Valid/ready: a beat transfers on a rising edge where TVALID and TREADY are both high.
  // The output register can take a new beat when it is empty or is being drained this cycle,
  // and only the granted source ever sees TREADY.
  assign w_out_free     = !r_m_tvalid || M_AXIS_TREADY;
  assign S0_AXIS_TREADY = (r_state == ST_GNT0) && w_out_free;
  assign S1_AXIS_TREADY = (r_state == ST_GNT1) && w_out_free;
  assign w_acc0         = S0_AXIS_TREADY && S0_AXIS_TVALID;
  assign w_acc1         = S1_AXIS_TREADY && S1_AXIS_TVALID;
  assign w_acc          = w_acc0 || w_acc1;
  assign w_tlast_in     = w_acc1 ? S1_AXIS_TLAST : S0_AXIS_TLAST;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_m_tdata  <= '0;
      r_m_tkeep  <= '0;
      r_m_tuser  <= '0;
      r_m_tlast  <= 1'b0;
      r_m_tvalid <= 1'b0;
    end else if (w_acc) begin
      r_m_tdata  <= w_acc1 ? S1_AXIS_TDATA : S0_AXIS_TDATA;
      r_m_tkeep  <= w_acc1 ? S1_AXIS_TKEEP : S0_AXIS_TKEEP;
      r_m_tuser  <= w_acc1 ? S1_AXIS_TUSER : S0_AXIS_TUSER;
      r_m_tlast  <= w_tlast_in;
      r_m_tvalid <= 1'b1;
    end else if (M_AXIS_TREADY) begin
      r_m_tvalid <= 1'b0;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state    <= ST_IDLE;
      r_rr_ptr   <= 1'b0;
      r_grant_id <= 1'b0;
      r_beat_cnt <= '0;
      r_overrun  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // r_rr_ptr only matters when both sources are waiting.
          if (S0_AXIS_TVALID && (!S1_AXIS_TVALID || !r_rr_ptr)) begin
            r_state    <= ST_GNT0;
            r_grant_id <= 1'b0;
            r_beat_cnt <= '0;
          end else if (S1_AXIS_TVALID) begin
            r_state    <= ST_GNT1;
            r_grant_id <= 1'b1;
            r_beat_cnt <= '0;
          end
        end
        ST_GNT0, ST_GNT1: begin
          if (w_acc) begin
            if (r_beat_cnt != MAX_CNT) begin
              r_beat_cnt <= r_beat_cnt + 1'b1;
            end
            if ((r_beat_cnt == MAX_CNT) && !w_tlast_in) begin
              r_overrun <= 1'b1;
            end
            if (w_tlast_in) begin
              r_rr_ptr <= (r_state == ST_GNT0);
              r_state  <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign M_AXIS_TDATA      = r_m_tdata;
  assign M_AXIS_TKEEP      = r_m_tkeep;
  assign M_AXIS_TUSER      = r_m_tuser;
  assign M_AXIS_TLAST      = r_m_tlast;
  assign M_AXIS_TVALID     = r_m_tvalid;
  assign grant_id          = r_grant_id;
  assign error_pkt_overrun = r_overrun;
  assign o_dbg_state       = r_state;

endmodule

// File: tb/tb_axi4_tlp_rr_arbiter.sv
// Directed bench for axi4_tlp_rr_arbiter: per-source beat queues feed the inputs, a monitor
// records output beats, and each scenario task compares them against hand-built expectations.
module tb_axi4_tlp_rr_arbiter;

  localparam int TUL  = 161;
  localparam int MAXB = 4;
  localparam int BW   = 1 + 16 + TUL + 512;

  typedef struct packed {
    logic           last;
    logic [15:0]    keep;
    logic [TUL-1:0] user;
    logic [511:0]   data;
  } beat_t;

  logic       ACLK = 1'b0;
  logic       ARESETN;
  beat_t      s0_b;
  beat_t      s1_b;
  logic       s0_valid;
  logic       s1_valid;
  logic       s0_ready;
  logic       s1_ready;
  logic [511:0]   m_tdata;
  logic [15:0]    m_tkeep;
  logic [TUL-1:0] m_tuser;
  logic           m_tlast;
  logic           m_tvalid;
  logic           m_ready;
  logic           grant_id;
  logic           err;
  logic [1:0]     dbg_state;
  logic [BW-1:0]  m_cur;

  logic [BW-1:0] src_q0[$];
  logic [BW-1:0] src_q1[$];
  logic [BW-1:0] exp_q[$];
  logic [BW-1:0] obs_q[$];
  int            obs_cyc[$];
  int            cyc = 0;
  int            n_checks = 0;
  int            n_pass = 0;

  assign m_cur = {m_tlast, m_tkeep, m_tuser, m_tdata};

  axi4_tlp_rr_arbiter #(.AXI_TUSER_L(TUL), .MAX_BEATS(MAXB)) dut (
    .ACLK              (ACLK),
    .ARESETN           (ARESETN),
    .S0_AXIS_TDATA     (s0_b.data),
    .S0_AXIS_TKEEP     (s0_b.keep),
    .S0_AXIS_TUSER     (s0_b.user),
    .S0_AXIS_TLAST     (s0_b.last),
    .S0_AXIS_TVALID    (s0_valid),
    .S0_AXIS_TREADY    (s0_ready),
    .S1_AXIS_TDATA     (s1_b.data),
    .S1_AXIS_TKEEP     (s1_b.keep),
    .S1_AXIS_TUSER     (s1_b.user),
    .S1_AXIS_TLAST     (s1_b.last),
    .S1_AXIS_TVALID    (s1_valid),
    .S1_AXIS_TREADY    (s1_ready),
    .M_AXIS_TDATA      (m_tdata),
    .M_AXIS_TKEEP      (m_tkeep),
    .M_AXIS_TUSER      (m_tuser),
    .M_AXIS_TLAST      (m_tlast),
    .M_AXIS_TVALID     (m_tvalid),
    .M_AXIS_TREADY     (m_ready),
    .grant_id          (grant_id),
    .error_pkt_overrun (err),
    .o_dbg_state       (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial forever #5 ACLK = ~ACLK;
  always @(posedge ACLK) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got time %0t, want < 200000", $time);
    $fatal(1);
  end

  // ---------------- drivers ----------------
  initial begin
    bit fire;
    s0_valid = 1'b0;
    s0_b     = '0;
    forever begin
      @(negedge ACLK);
      fire = s0_valid && s0_ready;
      @(posedge ACLK);
      #1;
      if (fire && src_q0.size() > 0) void'(src_q0.pop_front());
      if (src_q0.size() > 0) begin
        s0_b     = src_q0[0];
        s0_valid = 1'b1;
      end else begin
        s0_valid = 1'b0;
      end
    end
  end

  initial begin
    bit fire;
    s1_valid = 1'b0;
    s1_b     = '0;
    forever begin
      @(negedge ACLK);
      fire = s1_valid && s1_ready;
      @(posedge ACLK);
      #1;
      if (fire && src_q1.size() > 0) void'(src_q1.pop_front());
      if (src_q1.size() > 0) begin
        s1_b     = src_q1[0];
        s1_valid = 1'b1;
      end else begin
        s1_valid = 1'b0;
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge ACLK) begin
    if (ARESETN && m_tvalid && m_ready) begin
      obs_q.push_back(m_cur);
      obs_cyc.push_back(cyc);
    end
  end

  function automatic logic [BW-1:0] mk(input logic [31:0] d, input logic last);
    beat_t b;
    b            = '0;
    b.data       = {16{d}};
    b.keep       = 16'hFFFF >> d[2:0];
    b.user[31:0] = d;
    b.user[96:64] = {1'b1, ~d};
    b.user[160]  = d[0];
    b.last       = last;
    return b;
  endfunction

  // Called at a negedge so the drivers pick the beats up at the next rising edge.
  task automatic send_pkt(input int src, input logic [31:0] base, input int n, input bit expect_it);
    for (int i = 0; i < n; i++) begin
      if (src == 0) src_q0.push_back(mk(base + 32'(i), i == n - 1));
      else          src_q1.push_back(mk(base + 32'(i), i == n - 1));
      if (expect_it) exp_q.push_back(mk(base + 32'(i), i == n - 1));
    end
  endtask

  task automatic apply_reset();
    ARESETN = 1'b0;
    m_ready = 1'b1;
    src_q0.delete();
    src_q1.delete();
    exp_q.delete();
    obs_q.delete();
    obs_cyc.delete();
    repeat (3) @(posedge ACLK);
    #1 ARESETN = 1'b1;
    @(negedge ACLK);
  endtask

  // ---------------- scoreboard ----------------
  task automatic score_stream(input string tag, input int budget);
    int    k;
    beat_t got;
    beat_t want;
    k = 0;
    while (obs_q.size() < exp_q.size() && k < budget) begin
      @(posedge ACLK);
      k++;
    end
    repeat (4) @(posedge ACLK);
    n_checks++;
    if (obs_q.size() != exp_q.size())
      $display("FAIL %s_beat_count: got %0d beats, want %0d", tag, obs_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; exp_q.size() > 0 && obs_q.size() > 0; i++) begin
      got  = obs_q.pop_front();
      want = exp_q.pop_front();
      n_checks++;
      if (got !== want)
        $display("FAIL %s_beat%0d: got data=%h user[96:64]=%h keep=%h last=%b, want data=%h user[96:64]=%h keep=%h last=%b",
                 tag, i, got.data[31:0], got.user[96:64], got.keep, got.last,
                 want.data[31:0], want.user[96:64], want.keep, want.last);
      else n_pass++;
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    ARESETN = 1'b0;
    m_ready = 1'b1;
    repeat (2) @(negedge ACLK);
    n_checks++;
    if ({m_tvalid, m_cur} !== '0) $display("FAIL reset_outputs: got valid=%b data=%h, want 0", m_tvalid, m_tdata[31:0]);
    else n_pass++;
    n_checks++;
    if ({s0_ready, s1_ready, grant_id, err, dbg_state} !== 6'b0)
      $display("FAIL reset_ctrl: got rdy0=%b rdy1=%b gnt=%b err=%b st=%0d, want all 0", s0_ready, s1_ready, grant_id, err, dbg_state);
    else n_pass++;
    apply_reset();
    n_checks++;
    if ({m_tvalid, dbg_state} !== 3'b0) $display("FAIL reset_release: got valid=%b st=%0d, want 0/0", m_tvalid, dbg_state);
    else n_pass++;
  endtask

  task automatic test_single_source();
    int s1_busy;
    apply_reset();
    send_pkt(0, 32'hA1, 3, 1'b1);
    s1_busy = 0;
    repeat (8) begin
      @(negedge ACLK);
      if (s1_ready !== 1'b0) s1_busy++;
    end
    n_checks++;
    if (s1_busy != 0) $display("FAIL t1_s1_tready: got %0d cycles high, want 0", s1_busy);
    else n_pass++;
    n_checks++;
    if (grant_id !== 1'b0) $display("FAIL t1_grant_id: got %b, want 0", grant_id);
    else n_pass++;
    n_checks++;
    if (obs_cyc.size() != 3 || obs_cyc[1] != obs_cyc[0] + 1 || obs_cyc[2] != obs_cyc[1] + 1)
      $display("FAIL t1_consecutive: got %0d beats not on consecutive cycles, want 3 consecutive", obs_cyc.size());
    else n_pass++;
    score_stream("t1", 30);
  endtask

  task automatic test_rr_fairness();
    apply_reset();
    for (int p = 0; p < 3; p++) begin
      send_pkt(0, 32'h200 + 32'(p * 16), 2, 1'b1);
      send_pkt(1, 32'h280 + 32'(p * 16), 2, 1'b1);
    end
    score_stream("t2", 80);
  endtask

  task automatic test_backpressure();
    bit            pat [8];
    bit            prev_stall;
    logic [BW-1:0] held;
    apply_reset();
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    send_pkt(1, 32'h300, 4, 1'b1);
    for (int k = 0; k < 20 && !m_tvalid; k++) begin
      @(posedge ACLK);
      #1;
    end
    prev_stall = 1'b0;
    held       = '0;
    for (int i = 0; i < 8; i++) begin
      m_ready = pat[i];
      @(negedge ACLK);
      if (prev_stall) begin
        n_checks++;
        if (m_cur !== held) $display("FAIL t3_stable%0d: got data=%h, want held data=%h", i, m_tdata[31:0], held[31:0]);
        else n_pass++;
      end
      prev_stall = m_tvalid && !m_ready;
      if (prev_stall) begin
        held = m_cur;
        n_checks++;
        if (s1_ready !== 1'b0) $display("FAIL t3_s1_tready%0d: got %b during stall, want 0", i, s1_ready);
        else n_pass++;
      end
      @(posedge ACLK);
      #1;
    end
    m_ready = 1'b1;
    score_stream("t3", 30);
  endtask

  task automatic test_back_to_back_single();
    apply_reset();
    for (int p = 0; p < 3; p++) begin
      send_pkt(0, 32'h600 + 32'(p), 1, 1'b1);
      send_pkt(1, 32'h680 + 32'(p), 1, 1'b1);
    end
    score_stream("t6", 60);
    for (int i = 1; i < 6; i++) begin
      n_checks++;
      if (obs_cyc.size() != 6 || obs_cyc[i] != obs_cyc[i-1] + 2)
        $display("FAIL t6_spacing%0d: got %0d cycles between packets (beats=%0d), want 2",
                 i, (obs_cyc.size() == 6) ? obs_cyc[i] - obs_cyc[i-1] : -1, obs_cyc.size());
      else n_pass++;
    end
    n_checks++;
    if (err !== 1'b0) $display("FAIL t6_error_flag: got %b, want 0", err);
    else n_pass++;
  endtask

  task automatic test_overrun();
    int n;
    apply_reset();
    send_pkt(0, 32'h400, 6, 1'b1);
    send_pkt(1, 32'h480, 2, 1'b1);
    n = 0;
    for (int k = 0; k < 40 && n < 8; k++) begin
      @(negedge ACLK);
      if (m_tvalid) begin
        n++;
        if (n == 4) begin
          n_checks++;
          if (err !== 1'b0) $display("FAIL t4_flag_beat4: got %b, want 0", err);
          else n_pass++;
        end
        if (n == 5) begin
          n_checks++;
          if (err !== 1'b1) $display("FAIL t4_flag_beat5: got %b, want 1", err);
          else n_pass++;
        end
      end
    end
    score_stream("t4", 40);
    n_checks++;
    if (err !== 1'b1) $display("FAIL t4_flag_sticky: got %b, want 1", err);
    else n_pass++;
  endtask

  task automatic test_reset_mid_packet();
    obs_cyc.delete();
    send_pkt(0, 32'h500, 1, 1'b1);
    score_stream("t5a", 20);
    send_pkt(0, 32'h510, 5, 1'b0);
    for (int k = 0; k < 20 && !m_tvalid; k++) begin
      @(posedge ACLK);
      #1;
    end
    #1 ARESETN = 1'b0;
    #1;
    n_checks++;
    if ({m_tvalid, m_cur} !== '0) $display("FAIL t5_async_outputs: got valid=%b data=%h, want 0", m_tvalid, m_tdata[31:0]);
    else n_pass++;
    n_checks++;
    if ({s0_ready, s1_ready, grant_id, err, dbg_state} !== 6'b0)
      $display("FAIL t5_async_ctrl: got rdy0=%b rdy1=%b gnt=%b err=%b st=%0d, want all 0", s0_ready, s1_ready, grant_id, err, dbg_state);
    else n_pass++;
    src_q0.delete();
    exp_q.delete();
    obs_q.delete();
    repeat (2) @(posedge ACLK);
    #1 ARESETN = 1'b1;
    @(negedge ACLK);
    send_pkt(0, 32'h5C0, 1, 1'b1);
    send_pkt(1, 32'h580, 2, 1'b1);
    score_stream("t5b", 40);
    n_checks++;
    if (grant_id !== 1'b1) $display("FAIL t5_grant_id: got %b, want 1", grant_id);
    else n_pass++;
  endtask

  initial begin
    ARESETN = 1'b0;
    m_ready = 1'b1;
    test_reset();
    test_single_source();
    test_rr_fairness();
    test_backpressure();
    test_back_to_back_single();
    test_overrun();
    test_reset_mid_packet();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
